murax_spi_slave: RTL and testbench

SPI mode-0 responder for the Murax SoC. It is the peer of the on-chip SPI master: an external SPI controller clocks bytes into the SoC, and the SoC returns bytes on MISO. All pin inputs are oversampled in the `io_mainClk` domain. The SoC side has a byte stream in each direction. The block sits between the board pins (SCK/MOSI/SS in, MISO as a tristate pad) and the APB peripheral wrapper.

---
 rtl/murax_spi_slave_if.sv | 30 +++
 rtl/murax_spi_slave.sv | 211 +++++++++++++++++++++
 tb/tb_murax_spi_slave.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/murax_spi_slave_if.sv
// SoC-facing and pin-facing signal bundle of the Murax SPI responder.
// The slave modport is the responder's view; the master modport is the driver's view.
interface murax_spi_slave_if;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic       miso_write;
  logic       miso_writeEnable;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_payload;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_payload;
  logic       overrun;
  logic       underrun;
  logic       clearFlags;

  modport slave (
    input  sclk, ss, mosi, tx_valid, tx_payload, rx_ready, clearFlags,
    output miso_write, miso_writeEnable, tx_ready, rx_valid, rx_payload,
           overrun, underrun
  );

  modport master (
    output sclk, ss, mosi, tx_valid, tx_payload, rx_ready, clearFlags,
    input  miso_write, miso_writeEnable, tx_ready, rx_valid, rx_payload,
           overrun, underrun
  );
endinterface

// File: rtl/murax_spi_slave.sv
// SPI mode-0 responder, pins oversampled in the io_mainClk domain.
// Define MURAX_SPI_SLAVE_RX_FIFO_EN for a 4-entry RX FIFO instead of a single RX holding register.
module murax_spi_slave #(
  parameter logic [7:0]  DEFAULT_TX  = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              io_mainClk,
  input logic              io_asyncReset,
  murax_spi_slave_if.slave bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, warm_q;
  logic                   sclk_hist, ss_hist, armed_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic                   load_tx, shift_tx, sample_rx, end_frame;
  logic [7:0]             tx_shift, tx_hold;
  logic [6:0]             rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   byte_seen, byte_done;
  logic                   push_pend;
  logic [7:0]             push_data;

  logic                   miso_write_q, miso_oe_q;
  logic                   tx_ready_q, tx_accept;
  logic                   rx_valid_q, rx_pop, rx_push_ok;
  logic [7:0]             rx_payload_q;
  logic                   overrun_q, underrun_q;

  // Pin synchronizers plus history flops; SS resets high so reset reads as deselected
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b1;
      warm_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   bus.ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_hist <= sclk_s;
      ss_hist   <= ss_s;
      warm_q    <= {warm_q[SYNC_STAGES-2:0], 1'b1};
      // Only arm once SS has really been seen high, so a frame in flight at reset release is skipped
      armed_q   <= armed_q | (warm_q[SYNC_STAGES-1] & ss_s);
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign ss_fall   = ~ss_s & ss_hist & armed_q;
  assign ss_rise   = ss_s & ~ss_hist;

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Frame sequencing; SS rise takes priority over any coincident SCK edge
  always_comb begin
    state_d   = state_q;
    load_tx   = 1'b0;
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    end_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          load_tx = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end else if (sclk_rise) begin
          sample_rx = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt != '0) shift_tx = 1'b1;
          else if (byte_seen) load_tx = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_done = sample_rx && (bit_cnt == CNT_W'(7));
  assign tx_accept = bus.tx_valid & tx_ready_q;

  // Shift datapath, TX holding register and pad drivers
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      tx_shift     <= '0;
      tx_hold      <= '0;
      tx_ready_q   <= 1'b1;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      byte_seen    <= 1'b0;
      push_pend    <= 1'b0;
      push_data    <= '0;
      miso_write_q <= 1'b1;
      miso_oe_q    <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (load_tx)       tx_shift <= tx_ready_q ? DEFAULT_TX : tx_hold;
      else if (shift_tx) tx_shift <= {tx_shift[6:0], 1'b0};

      if (tx_accept) tx_hold <= bus.tx_payload;
      if (tx_accept)                    tx_ready_q <= 1'b0;
      else if (load_tx && !tx_ready_q)  tx_ready_q <= 1'b1;

      if (sample_rx) rx_shift <= {rx_shift[5:0], mosi_s};

      if (end_frame)      bit_cnt <= '0;
      else if (sample_rx) bit_cnt <= bit_cnt + CNT_W'(1);

      if (end_frame || state_q == IDLE) byte_seen <= 1'b0;
      else if (byte_done)               byte_seen <= 1'b1;

      // Completed byte is staged one cycle before it reaches the RX buffer
      push_pend <= byte_done;
      if (byte_done) push_data <= {rx_shift, mosi_s};

      miso_write_q <= (state_q == SHIFT) ? tx_shift[7] : 1'b1;
      miso_oe_q    <= (state_q == SHIFT);

      underrun_q <= (load_tx & tx_ready_q) | (underrun_q & ~bus.clearFlags);
      overrun_q  <= (push_pend & ~rx_push_ok) | (overrun_q & ~bus.clearFlags);
    end
  end

  assign rx_pop = rx_valid_q & bus.rx_ready;

`ifdef MURAX_SPI_SLAVE_RX_FIFO_EN
  localparam int unsigned RX_DEPTH = 4;
  localparam int unsigned PTR_W    = 2;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic             rx_full_q, rx_full_d;
  logic [7:0]       head_d;

  // Circular FIFO bookkeeping; the full bit separates full from empty when pointers meet
  always_comb begin
    rx_push_ok = push_pend & (~rx_full_q | rx_pop);
    rd_ptr_d   = rd_ptr + PTR_W'(rx_pop);
    wr_ptr_d   = wr_ptr + PTR_W'(rx_push_ok);
    rx_full_d  = rx_full_q;
    if (rx_push_ok && !rx_pop && wr_ptr_d == rd_ptr) rx_full_d = 1'b1;
    else if (rx_pop && !rx_push_ok)                  rx_full_d = 1'b0;
    head_d = (rx_push_ok && wr_ptr == rd_ptr_d) ? push_data : rx_mem[rd_ptr_d];
  end

  always_ff @(posedge io_mainClk) begin
    if (rx_push_ok) rx_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rx_full_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_payload_q <= '0;
    end else begin
      wr_ptr       <= wr_ptr_d;
      rd_ptr       <= rd_ptr_d;
      rx_full_q    <= rx_full_d;
      rx_valid_q   <= rx_full_d | (wr_ptr_d != rd_ptr_d);
      rx_payload_q <= head_d;
    end
  end
`else
  // Single RX holding register; a pop in the same cycle frees room for the push
  assign rx_push_ok = push_pend & (~rx_valid_q | rx_pop);

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      rx_valid_q   <= 1'b0;
      rx_payload_q <= '0;
    end else begin
      rx_valid_q <= rx_push_ok | (rx_valid_q & ~rx_pop);
      if (rx_push_ok) rx_payload_q <= push_data;
    end
  end
`endif

  assign bus.miso_write       = miso_write_q;
  assign bus.miso_writeEnable = miso_oe_q;
  assign bus.tx_ready         = tx_ready_q;
  assign bus.rx_valid         = rx_valid_q;
  assign bus.rx_payload       = rx_payload_q;
  assign bus.overrun          = overrun_q;
  assign bus.underrun         = underrun_q;

endmodule

// File: tb/tb_murax_spi_slave.sv
// Directed bench for murax_spi_slave: SPI master model at mainClk/8, byte streams, flags and reset.
module tb_murax_spi_slave;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [39:0] mi;

  always #5 clk = ~clk;

  murax_spi_slave_if bus ();

  murax_spi_slave dut (
    .io_mainClk    (clk),
    .io_asyncReset (rst),
    .bus           (bus)
  );

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One SS frame of nbits; SS is released while SCK is still high, then SCK returns low
  task automatic frame(input logic [39:0] mo, input int nbits, output logic [39:0] so);
    so       = '0;
    bus.ss   = 1'b0;
    bus.mosi = mo[nbits-1];
    for (int i = nbits - 1; i >= 0; i--) begin
      wait_cyc(4);
      so[i]    = bus.miso_write;
      bus.sclk = 1'b1;
      wait_cyc(4);
      if (i != 0) begin
        bus.sclk = 1'b0;
        bus.mosi = mo[i-1];
      end
    end
    bus.ss = 1'b1;
    wait_cyc(4);
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    wait_cyc(6);
  endtask

  task automatic tx_push(input logic [7:0] b);
    chk("tx_ready_before_push", 40'(bus.tx_ready), 40'd1);
    bus.tx_payload = b;
    bus.tx_valid   = 1'b1;
    wait_cyc(1);
    bus.tx_valid = 1'b0;
    chk("tx_ready_after_push", 40'(bus.tx_ready), 40'd0);
  endtask

  task automatic rx_pop(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 40'(bus.rx_valid), 40'd1);
    chk({tag, "_payload"}, 40'(bus.rx_payload), 40'(exp));
    bus.rx_ready = 1'b1;
    wait_cyc(1);
    bus.rx_ready = 1'b0;
    wait_cyc(1);
  endtask

  task automatic clear_flags();
    bus.clearFlags = 1'b1;
    wait_cyc(1);
    bus.clearFlags = 1'b0;
    wait_cyc(1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.sclk       = 1'b0;
    bus.ss         = 1'b1;
    bus.mosi       = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_payload = '0;
    bus.rx_ready   = 1'b0;
    bus.clearFlags = 1'b0;
    wait_cyc(3);

    chk("rst_miso",     40'(bus.miso_write),       40'd1);
    chk("rst_oe",       40'(bus.miso_writeEnable), 40'd0);
    chk("rst_tx_ready", 40'(bus.tx_ready),         40'd1);
    chk("rst_rx_valid", 40'(bus.rx_valid),         40'd0);
    chk("rst_payload",  40'(bus.rx_payload),       40'h0);
    chk("rst_overrun",  40'(bus.overrun),          40'd0);
    chk("rst_underrun", 40'(bus.underrun),         40'd0);
    rst = 1'b0;
    wait_cyc(10);

    // Single byte each way
    tx_push(8'hA5);
    frame(40'h3C, 8, mi);
    chk("single_miso", mi[7:0], 40'hA5);
    chk("single_oe_after", 40'(bus.miso_writeEnable), 40'd0);
    chk("single_tx_drained", 40'(bus.tx_ready), 40'd1);
    chk("single_overrun", 40'(bus.overrun), 40'd0);
    chk("single_underrun", 40'(bus.underrun), 40'd0);
    rx_pop("single_rx", 8'h3C);
    chk("single_rx_empty", 40'(bus.rx_valid), 40'd0);

    // Underrun over a two-byte frame, consumer always ready
    bus.rx_ready = 1'b1;
    frame(40'h1122, 16, mi);
    bus.rx_ready = 1'b0;
    wait_cyc(1);
    chk("underrun_miso", mi[15:0], 40'hFFFF);
    chk("underrun_flag", 40'(bus.underrun), 40'd1);
    chk("underrun_no_overrun", 40'(bus.overrun), 40'd0);
    chk("underrun_rx_drained", 40'(bus.rx_valid), 40'd0);
    clear_flags();
    chk("underrun_cleared", 40'(bus.underrun), 40'd0);

    // Overrun with the consumer stalled
`ifdef MURAX_SPI_SLAVE_RX_FIFO_EN
    for (int b = 1; b <= 4; b++) frame(40'(b), 8, mi);
    chk("fifo_no_overrun_4", 40'(bus.overrun), 40'd0);
    frame(40'h05, 8, mi);
    chk("fifo_overrun_5", 40'(bus.overrun), 40'd1);
    for (int b = 1; b <= 4; b++) rx_pop("fifo_drain", 8'(b));
    chk("fifo_empty", 40'(bus.rx_valid), 40'd0);
`else
    frame(40'h01, 8, mi);
    chk("hold_no_overrun_1", 40'(bus.overrun), 40'd0);
    frame(40'h02, 8, mi);
    chk("hold_overrun_2", 40'(bus.overrun), 40'd1);
    rx_pop("hold_keep_first", 8'h01);
    chk("hold_empty", 40'(bus.rx_valid), 40'd0);
`endif
    clear_flags();
    chk("flags_cleared_ovr", 40'(bus.overrun), 40'd0);
    chk("flags_cleared_und", 40'(bus.underrun), 40'd0);

    // Abort after five SCK rises, then a clean frame
    frame(40'h15, 5, mi);
    chk("abort_miso_default", mi[4:0], 40'h1F);
    chk("abort_oe", 40'(bus.miso_writeEnable), 40'd0);
    chk("abort_no_push", 40'(bus.rx_valid), 40'd0);
    clear_flags();
    tx_push(8'h5A);
    frame(40'hC3, 8, mi);
    chk("post_abort_miso", mi[7:0], 40'h5A);
    rx_pop("post_abort_rx", 8'hC3);
    chk("post_abort_underrun", 40'(bus.underrun), 40'd0);

    // Asynchronous reset during bit 3, released with SS still low
    tx_push(8'h77);
    bus.ss   = 1'b0;
    bus.mosi = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < 3; i++) begin
      bus.sclk = 1'b1; wait_cyc(4);
      bus.sclk = 1'b0; wait_cyc(4);
    end
    chk("midframe_oe", 40'(bus.miso_writeEnable), 40'd1);
    bus.sclk = 1'b1;
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(1);
    chk("arst_miso",     40'(bus.miso_write),       40'd1);
    chk("arst_oe",       40'(bus.miso_writeEnable), 40'd0);
    chk("arst_tx_ready", 40'(bus.tx_ready),         40'd1);
    chk("arst_rx_valid", 40'(bus.rx_valid),         40'd0);
    chk("arst_payload",  40'(bus.rx_payload),       40'h0);
    chk("arst_overrun",  40'(bus.overrun),          40'd0);
    chk("arst_underrun", 40'(bus.underrun),         40'd0);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);
    bus.sclk = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < 8; i++) begin
      bus.sclk = 1'b1; wait_cyc(4);
      bus.sclk = 1'b0; wait_cyc(4);
    end
    chk("arst_stale_oe", 40'(bus.miso_writeEnable), 40'd0);
    chk("arst_stale_no_push", 40'(bus.rx_valid), 40'd0);
    chk("arst_stale_underrun", 40'(bus.underrun), 40'd0);
    bus.ss   = 1'b1;
    bus.mosi = 1'b0;
    wait_cyc(8);

    tx_push(8'h96);
    frame(40'h69, 8, mi);
    chk("post_reset_miso", mi[7:0], 40'h96);
    rx_pop("post_reset_rx", 8'h69);
    chk("post_reset_underrun", 40'(bus.underrun), 40'd0);
    chk("post_reset_overrun", 40'(bus.overrun), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
